pulse_train_gen: RTL

- Upstream stimulus stage for the clk1 capture register: generates programmable single/multi-cycle pulse trains on data_out, which feeds the clk1-sampled d_in register and the derived-clock capture stage behind it.
- Fully synchronous to clk1. A start/busy/done handshake lets a bench or sequencer launch a train: initial delay, pulse width, inter-pulse gap and pulse count.

---
 rtl/pulse_train_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator on clk1: start/busy/done handshake launches
// a train of num pulses (width high, gap low) after an initial delay.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last pulses_sent
// DELAY | counting the initial delay before the first rise
// HIGH  | data_out high for max(width,1) cycles
// GAP   | data_out low for max(gap,1) cycles between pulses
module pulse_train_gen #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [NUM_W-1:0] num,
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulses_sent
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] width_m1, gap_m1;
  logic [CNT_W-1:0] width_m1_in, gap_m1_in;
  logic [NUM_W-1:0] num_q;
  logic [NUM_W-1:0] sent_nxt, sent_inc;
  logic             data_nxt, busy_nxt, done_nxt, capture;

  // Zero width/gap is clamped to one cycle, so the reload value never wraps.
  assign width_m1_in = (width == '0) ? '0 : width - CNT_W'(1);
  assign gap_m1_in   = (gap == '0)   ? '0 : gap - CNT_W'(1);
  assign sent_inc    = pulses_sent + NUM_W'(1);

  always_ff @(posedge clk1) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      data_out    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_sent <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      data_out    <= data_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pulses_sent <= sent_nxt;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      width_m1 <= '0;
      gap_m1   <= '0;
      num_q    <= '0;
    end else if (capture) begin
      width_m1 <= width_m1_in;
      gap_m1   <= gap_m1_in;
      num_q    <= num;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_out;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    sent_nxt  = pulses_sent;
    capture   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          capture   = 1'b1;
          state_nxt = DELAY;
          cnt_nxt   = delay;
          busy_nxt  = 1'b1;
          sent_nxt  = '0;
          data_nxt  = 1'b0;
        end
      end
      DELAY: begin
        if (cnt == '0) begin
          if (num_q == '0) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = HIGH;
            data_nxt  = 1'b1;
            cnt_nxt   = width_m1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          data_nxt = 1'b0;
          sent_nxt = sent_inc;
          if (sent_inc == num_q) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = gap_m1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = HIGH;
          data_nxt  = 1'b1;
          cnt_nxt   = width_m1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort cancels everything in flight; a partially driven pulse is not counted.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      data_nxt  = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      sent_nxt  = pulses_sent;
      capture   = 1'b0;
    end
  end

endmodule
